// File: rtl/axis_invert_pipe.sv
// rtl/axis_invert_pipe.sv - AXI-Stream per-bit inverter with skid-buffered register slices and frame counter
module axis_invert_pipe #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] INVERT_MASK = '0,
    parameter int unsigned           STAGES      = 2,
    parameter int unsigned           COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   invert_en,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    // A beat travels as {tlast, tdata} through every stage.
    localparam int unsigned BW = DATA_WIDTH + 1;

    logic [BW-1:0]     stage_beat [STAGES];
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_ready;
    logic [BW-1:0]     in_beat;

    logic [COUNT_WIDTH-1:0] frame_count_q;
    logic [COUNT_WIDTH-1:0] frame_count_d;

    // invert_en is applied here, so it only affects the beat it arrives with.
    assign in_beat = {s_axis_tlast, s_axis_tdata ^ (invert_en ? INVERT_MASK : '0)};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic          in_valid;
        logic [BW-1:0] in_data;
        logic          out_ready;
        logic          in_fire;
        logic          out_fire;
        logic          main_valid_q;
        logic          main_valid_d;
        logic          skid_valid_q;
        logic          skid_valid_d;
        logic [BW-1:0] main_q;
        logic [BW-1:0] main_d;
        logic [BW-1:0] skid_q;
        logic [BW-1:0] skid_d;

        if (g == 0) begin : g_first
            assign in_valid = s_axis_tvalid;
            assign in_data  = in_beat;
        end else begin : g_inner
            assign in_valid = stage_valid[g-1];
            assign in_data  = stage_beat[g-1];
        end

        if (g == STAGES - 1) begin : g_last
            assign out_ready = m_axis_tready;
        end else begin : g_mid
            assign out_ready = stage_ready[g+1];
        end

        // Ready depends only on the registered skid flag, which breaks the
        // combinational ready path between neighbouring stages.
        assign in_fire  = in_valid && !skid_valid_q;
        assign out_fire = main_valid_q && out_ready;

        // Next state: refill main from skid first, else from the input; park
        // the input in skid only when main is full and not draining.
        always_comb begin
            main_valid_d = main_valid_q;
            main_d       = main_q;
            skid_valid_d = skid_valid_q;
            skid_d       = skid_q;
            if (skid_valid_q) begin
                if (out_fire) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                if (!main_valid_q || out_fire) begin
                    main_d       = in_data;
                    main_valid_d = 1'b1;
                end else begin
                    skid_d       = in_data;
                    skid_valid_d = 1'b1;
                end
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end

        // Stage registers; reset empties both slots and clears the data.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
                main_q       <= '0;
                skid_q       <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
                main_q       <= main_d;
                skid_q       <= skid_d;
            end
        end

        assign stage_valid[g] = main_valid_q;
        assign stage_beat[g]  = main_q;
        assign stage_ready[g] = !skid_valid_q;
    end

    assign s_axis_tready                 = stage_ready[0];
    assign m_axis_tvalid                 = stage_valid[STAGES-1];
    assign {m_axis_tlast, m_axis_tdata}  = stage_beat[STAGES-1];

    assign frame_count_d = (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                         ? frame_count_q + COUNT_WIDTH'(1) : frame_count_q;

    // Frame counter advances on every master-side tlast handshake and wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_invert_pipe.sv
// tb/tb_axis_invert_pipe.sv - directed self-checking bench for axis_invert_pipe
module tb_axis_invert_pipe;

    localparam int STG = 2;

    logic       clk;
    logic       reset;
    logic       invert_en;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tlast;
    logic       m_tvalid;
    logic       m_tready;
    logic [3:0] frame_count;

    int tests = 0;
    int fails = 0;

    logic [8:0] in_log [$];
    logic [8:0] out_log [$];
    int   cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   stab_err = 0;
    int   max_inflight = 0;
    int   tp_flag = 0;
    int   tp_stalls = 0;
    logic prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;

    axis_invert_pipe #(
        .DATA_WIDTH (8),
        .INVERT_MASK(8'hF0),
        .STAGES     (STG),
        .COUNT_WIDTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .invert_en    (invert_en),
        .s_axis_tdata (s_tdata),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedge monitor: records handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (s_tvalid && s_tready)
                in_log.push_back({s_tlast, s_tdata ^ (invert_en ? 8'hF0 : 8'h00)});
            if (m_tvalid && m_tready) begin
                if (out_log.size() == 0) first_cyc = cyc;
                last_cyc = cyc;
                out_log.push_back({m_tlast, m_tdata});
            end
            if (in_log.size() - out_log.size() > max_inflight)
                max_inflight = in_log.size() - out_log.size();
            if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} != prev_beat))
                stab_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
            if (tp_flag != 0 && !s_tready) tp_stalls++;
        end
    end

    initial begin
        int n;
        int sent;
        int cycles;
        int mism;
        int acc;
        logic hs;

        reset = 1'b1; invert_en = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        s_tvalid = 1'b0; m_tready = 1'b0;
        step(); step();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_s_tready", s_tready, 1);
        reset = 1'b0;
        step();

        // Single beat: A5 ^ F0 = 55, latency STAGES cycles from presentation
        in_log.delete(); out_log.delete();
        m_tready = 1'b1; invert_en = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        n = 0;
        while (!m_tvalid && n < 10) begin step(); n++; end
        chk("single_latency", n, STG - 1);
        chk("single_data", m_tdata, 8'h55);
        chk("single_last", m_tlast, 1);
        chk("single_fc_before", frame_count, 0);
        step();
        chk("single_fc_after", frame_count, 1);
        chk("single_drained", m_tvalid, 0);

        // Mode toggle: three zero beats with invert_en 1,0,1
        in_log.delete(); out_log.delete();
        s_tdata = 8'h00; s_tlast = 1'b0; s_tvalid = 1'b1;
        invert_en = 1'b1; step();
        invert_en = 1'b0; step();
        invert_en = 1'b1; step();
        s_tvalid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("toggle_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("toggle_b0", out_log[0], 9'h0F0);
            chk("toggle_b1", out_log[1], 9'h000);
            chk("toggle_b2", out_log[2], 9'h0F0);
        end

        // Full throughput: 64 back-to-back beats
        in_log.delete(); out_log.delete();
        invert_en = 1'b0; tp_stalls = 0; tp_flag = 1;
        for (int i = 0; i < 64; i++) begin
            s_tdata = 8'(i); s_tlast = (i == 63); s_tvalid = 1'b1;
            step();
        end
        tp_flag = 0; s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 0; i < STG + 3; i++) step();
        chk("tp_count", out_log.size(), 64);
        mism = 0;
        for (int i = 0; i < out_log.size() && i < 64; i++)
            if (out_log[i] !== {(i == 63), 8'(i)}) mism++;
        chk("tp_order", mism, 0);
        chk("tp_s_tready_stalls", tp_stalls, 0);
        chk("tp_no_bubbles", last_cyc - first_cyc, 63);

        // Random valid/ready, 1000 beats
        in_log.delete(); out_log.delete();
        stab_err = 0; max_inflight = 0;
        sent = 0; cycles = 0; s_tvalid = 1'b0;
        while (sent < 1000 && cycles < 20000) begin
            if (!s_tvalid && $urandom_range(0, 1) == 1) begin
                s_tvalid  = 1'b1;
                s_tdata   = 8'($urandom_range(0, 255));
                s_tlast   = ($urandom_range(0, 3) == 0);
                invert_en = 1'($urandom_range(0, 1));
            end
            m_tready = 1'($urandom_range(0, 1));
            hs = s_tvalid && s_tready;
            step(); cycles++;
            if (hs) begin sent++; s_tvalid = 1'b0; end
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        n = 0;
        while (out_log.size() < in_log.size() && n < 50) begin step(); n++; end
        chk("rand_budget", sent, 1000);
        chk("rand_in_count", in_log.size(), 1000);
        chk("rand_out_count", out_log.size(), 1000);
        mism = 0;
        for (int i = 0; i < out_log.size() && i < in_log.size(); i++)
            if (out_log[i] !== in_log[i]) mism++;
        chk("rand_order", mism, 0);
        chk("rand_stable", stab_err, 0);
        chk("rand_inflight_ok", (max_inflight <= 2 * STG), 1);

        // Fill to capacity, then reset mid-stream
        m_tready = 1'b0; invert_en = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            s_tdata = 8'(8'h10 + acc);
            hs = s_tready;
            step();
            if (hs) acc++;
        end
        chk("fill_count", acc, 2 * STG);
        chk("fill_s_tready", s_tready, 0);
        chk("fill_m_tvalid", m_tvalid, 1);
        s_tvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_s_tready", s_tready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        in_log.delete(); out_log.delete();
        m_tready = 1'b1; s_tdata = 8'h3C; s_tlast = 1'b1; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        n = 0;
        while (!m_tvalid && n < 10) begin step(); n++; end
        chk("post_rst_latency", n, STG - 1);
        chk("post_rst_data", m_tdata, 8'h3C);
        for (int i = 0; i < 6; i++) step();
        chk("post_rst_alone", out_log.size(), 1);
        chk("post_rst_fc", frame_count, 1);

        // Counter wrap with 4-bit frame_count
        reset = 1'b1; step(); reset = 1'b0;
        m_tready = 1'b1; s_tlast = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_tdata = 8'(i); s_tvalid = 1'b1;
            step();
            s_tvalid = 1'b0;
            step(); step(); step();
            chk($sformatf("wrap_fc_%0d", i + 1), frame_count, (i + 1) % 16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
